// File: rtl/tlb_pkg.sv
// Shared TLB entry layout, op codes and page-size constants for the pipelined TLB.
// Entry is packed MSB-first: vppn, ps, g, asid, e, even page, odd page.
package tlb_pkg;
    localparam int VPPN_W  = 19;
    localparam int PS_W    = 6;
    localparam int ASID_W  = 10;
    localparam int PPN_W   = 20;
    localparam int PAGE_W  = PPN_W + 6;
    localparam int ENTRY_W = VPPN_W + PS_W + 1 + ASID_W + 1 + 2 * PAGE_W;

    localparam int OFF_P1   = 0;
    localparam int OFF_P0   = OFF_P1 + PAGE_W;
    localparam int OFF_E    = OFF_P0 + PAGE_W;
    localparam int OFF_ASID = OFF_E + 1;
    localparam int OFF_G    = OFF_ASID + ASID_W;
    localparam int OFF_PS   = OFF_G + 1;
    localparam int OFF_VPPN = OFF_PS + PS_W;

    localparam logic [PS_W-1:0] PS_4K = 6'd12;
    localparam logic [PS_W-1:0] PS_4M = 6'd21;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    typedef struct packed {
        logic [PPN_W-1:0] ppn;
        logic [1:0]       plv;
        logic [1:0]       mat;
        logic             d;
        logic             v;
    } tlb_page_t;

    typedef struct packed {
        logic [VPPN_W-1:0] vppn;
        logic [PS_W-1:0]   ps;
        logic              g;
        logic [ASID_W-1:0] asid;
        logic              e;
        tlb_page_t         p0;
        tlb_page_t         p1;
    } tlb_entry_t;

    function automatic tlb_entry_t tlb_unpack(input logic [ENTRY_W-1:0] b);
        tlb_entry_t t;
        t.vppn = b[OFF_VPPN +: VPPN_W];
        t.ps   = b[OFF_PS +: PS_W];
        t.g    = b[OFF_G];
        t.asid = b[OFF_ASID +: ASID_W];
        t.e    = b[OFF_E];
        t.p0   = b[OFF_P0 +: PAGE_W];
        t.p1   = b[OFF_P1 +: PAGE_W];
        return t;
    endfunction

    function automatic logic [ENTRY_W-1:0] tlb_pack(input tlb_entry_t t);
        return t;
    endfunction

    // Only 4KB and 4MB pages exist; anything else is stored as 4KB.
    function automatic tlb_entry_t tlb_norm_ps(input tlb_entry_t t);
        tlb_entry_t r;
        r = t;
        if (t.ps != PS_4M) r.ps = PS_4K;
        return r;
    endfunction
endpackage

// File: rtl/tlb_match.sv
// Combinational TLB matcher: lowest-index hit with odd/even page select, plus per-entry
// VA and ASID match vectors for invalidate qualification. Zero latency, no flow control.
module tlb_match
    import tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IDXW   = $clog2(TLBNUM)
) (
    input  tlb_entry_t          i_ent [TLBNUM],
    input  logic [VPPN_W-1:0]   i_vppn,
    input  logic                i_va_bit12,
    input  logic [ASID_W-1:0]   i_asid,
    output logic                o_found,
    output logic [IDXW-1:0]     o_index,
    output tlb_page_t           o_page,
    output logic [PS_W-1:0]     o_ps,
    output logic [TLBNUM-1:0]   o_va_hit,
    output logic [TLBNUM-1:0]   o_asid_hit
);
    logic [TLBNUM-1:0] w_hit;

    always_comb begin
        w_hit      = '0;
        o_va_hit   = '0;
        o_asid_hit = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            o_va_hit[i]   = (i_ent[i].vppn[18:9] == i_vppn[18:9]) &&
                            ((i_ent[i].ps == PS_4M) || (i_ent[i].vppn[8:0] == i_vppn[8:0]));
            o_asid_hit[i] = (i_ent[i].asid == i_asid);
            w_hit[i]      = i_ent[i].e && o_va_hit[i] && (i_ent[i].g || o_asid_hit[i]);
        end
    end

    // Walk from the top so the lowest hitting index is the one left standing.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        o_page  = '0;
        o_ps    = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                o_found = 1'b1;
                o_index = IDXW'(i);
                o_ps    = i_ent[i].ps;
                if ((i_ent[i].ps == PS_4M) ? i_vppn[8] : i_va_bit12)
                    o_page = i_ent[i].p1;
                else
                    o_page = i_ent[i].p0;
            end
        end
    end
endmodule

// File: rtl/tlb_pipe.sv
// Pipelined TLB: two search ports answer one cycle after req; maintenance port runs
// IDLE->EXEC->RESP (3 cycles/op), op_ready low while busy, op_valid held until accepted.
module tlb_pipe
    import tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IDXW   = $clog2(TLBNUM),
    localparam int RES_W  = 1 + IDXW + PPN_W + PS_W + 2 + 2 + 1 + 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                s0_req,
    input  logic [18:0]         s0_vppn,
    input  logic                s0_va_bit12,
    input  logic [9:0]          s0_asid,
    output logic                s0_rvalid,
    output logic [RES_W-1:0]    s0_res,
    input  logic                s1_req,
    input  logic [18:0]         s1_vppn,
    input  logic                s1_va_bit12,
    input  logic [9:0]          s1_asid,
    output logic                s1_rvalid,
    output logic [RES_W-1:0]    s1_res,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [2:0]          op_code,
    input  logic [IDXW-1:0]     op_index,
    input  logic [4:0]          op_inv,
    input  logic [9:0]          op_asid,
    input  logic [18:0]         op_vppn,
    input  logic [ENTRY_W-1:0]  op_wentry,
    output logic                op_done,
    output logic                op_err,
    output logic                op_found,
    output logic [IDXW-1:0]     op_rindex,
    output logic [ENTRY_W-1:0]  op_rentry
);
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

    state_t            r_state;
    logic [TLBNUM-1:0] r_e;
    tlb_entry_t        r_ent [TLBNUM];
    tlb_entry_t        w_ent [TLBNUM];
    logic [IDXW-1:0]   r_fill_ptr;

    logic [2:0]        r_op_code;
    logic [IDXW-1:0]   r_op_index;
    logic [4:0]        r_op_inv;
    logic [9:0]        r_op_asid;
    logic [18:0]       r_op_vppn;
    tlb_entry_t        r_op_wentry;

    logic              r_op_ready, r_op_done, r_op_err, r_op_found;
    logic [IDXW-1:0]   r_op_rindex;
    logic [ENTRY_W-1:0] r_op_rentry;
    logic              r_s0_rvalid, r_s1_rvalid;
    logic [RES_W-1:0]  r_s0_res, r_s1_res;

    logic              w_s0_found, w_s1_found, w_m_found;
    logic [IDXW-1:0]   w_s0_index, w_s1_index, w_m_index;
    tlb_page_t         w_s0_page, w_s1_page;
    logic [PS_W-1:0]   w_s0_ps, w_s1_ps;
    logic [TLBNUM-1:0] w_m_va_hit, w_m_asid_hit, w_inv_sel;
    tlb_entry_t        w_wr;
    logic              w_err;

    // e lives in its own reset register; the rest of each entry is unreset storage.
    always_comb begin
        for (int i = 0; i < TLBNUM; i++) begin
            w_ent[i]   = r_ent[i];
            w_ent[i].e = r_e[i];
        end
    end

    tlb_match #(.TLBNUM(TLBNUM)) u_match_s0 (
        .i_ent(w_ent), .i_vppn(s0_vppn), .i_va_bit12(s0_va_bit12), .i_asid(s0_asid),
        .o_found(w_s0_found), .o_index(w_s0_index), .o_page(w_s0_page), .o_ps(w_s0_ps),
        .o_va_hit(), .o_asid_hit()
    );
    tlb_match #(.TLBNUM(TLBNUM)) u_match_s1 (
        .i_ent(w_ent), .i_vppn(s1_vppn), .i_va_bit12(s1_va_bit12), .i_asid(s1_asid),
        .o_found(w_s1_found), .o_index(w_s1_index), .o_page(w_s1_page), .o_ps(w_s1_ps),
        .o_va_hit(), .o_asid_hit()
    );
    tlb_match #(.TLBNUM(TLBNUM)) u_match_op (
        .i_ent(w_ent), .i_vppn(r_op_vppn), .i_va_bit12(1'b0), .i_asid(r_op_asid),
        .o_found(w_m_found), .o_index(w_m_index), .o_page(), .o_ps(),
        .o_va_hit(w_m_va_hit), .o_asid_hit(w_m_asid_hit)
    );

    assign w_wr  = tlb_norm_ps(r_op_wentry);
    assign w_err = (r_op_code > OP_INV) || ((r_op_code == OP_INV) && (r_op_inv > 5'd6));

    always_comb begin
        w_inv_sel = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            case (r_op_inv)
                5'd0, 5'd1: w_inv_sel[i] = 1'b1;
                5'd2:       w_inv_sel[i] = w_ent[i].g;
                5'd3:       w_inv_sel[i] = !w_ent[i].g;
                5'd4:       w_inv_sel[i] = !w_ent[i].g && w_m_asid_hit[i];
                5'd5:       w_inv_sel[i] = !w_ent[i].g && w_m_asid_hit[i] && w_m_va_hit[i];
                5'd6:       w_inv_sel[i] = (w_ent[i].g || w_m_asid_hit[i]) && w_m_va_hit[i];
                default:    w_inv_sel[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && (r_state == ST_EXEC) && !w_err) begin
            if (r_op_code == OP_WR)
                r_ent[r_op_index] <= w_wr;
            else if (r_op_code == OP_FILL)
                r_ent[r_fill_ptr] <= w_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_e         <= '0;
            r_fill_ptr  <= '0;
            r_op_code   <= '0;
            r_op_index  <= '0;
            r_op_inv    <= '0;
            r_op_asid   <= '0;
            r_op_vppn   <= '0;
            r_op_wentry <= '0;
            r_op_ready  <= 1'b1;
            r_op_done   <= 1'b0;
            r_op_err    <= 1'b0;
            r_op_found  <= 1'b0;
            r_op_rindex <= '0;
            r_op_rentry <= '0;
            r_s0_rvalid <= 1'b0;
            r_s1_rvalid <= 1'b0;
            r_s0_res    <= '0;
            r_s1_res    <= '0;
        end else begin
            r_s0_rvalid <= s0_req;
            r_s1_rvalid <= s1_req;
            if (s0_req)
                r_s0_res <= {w_s0_found, w_s0_index, w_s0_page.ppn, w_s0_ps,
                             w_s0_page.plv, w_s0_page.mat, w_s0_page.d, w_s0_page.v};
            if (s1_req)
                r_s1_res <= {w_s1_found, w_s1_index, w_s1_page.ppn, w_s1_ps,
                             w_s1_page.plv, w_s1_page.mat, w_s1_page.d, w_s1_page.v};
            r_op_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (op_valid) begin
                        r_op_code   <= op_code;
                        r_op_index  <= op_index;
                        r_op_inv    <= op_inv;
                        r_op_asid   <= op_asid;
                        r_op_vppn   <= op_vppn;
                        r_op_wentry <= tlb_unpack(op_wentry);
                        r_op_ready  <= 1'b0;
                        r_state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_state     <= ST_RESP;
                    r_op_done   <= 1'b1;
                    r_op_err    <= w_err;
                    r_op_found  <= (r_op_code == OP_SRCH) && w_m_found;
                    r_op_rindex <= (r_op_code == OP_SRCH) ? w_m_index :
                                   (r_op_code == OP_FILL) ? r_fill_ptr : '0;
                    r_op_rentry <= ((r_op_code == OP_RD) && w_ent[r_op_index].e) ?
                                   tlb_pack(w_ent[r_op_index]) : '0;
                    if (!w_err) begin
                        case (r_op_code)
                            OP_WR:   r_e[r_op_index] <= w_wr.e;
                            OP_FILL: begin
                                r_e[r_fill_ptr] <= w_wr.e;
                                r_fill_ptr      <= r_fill_ptr + IDXW'(1);
                            end
                            OP_INV:  r_e <= r_e & ~w_inv_sel;
                            default: ;
                        endcase
                    end
                end
                ST_RESP: begin
                    r_state    <= ST_IDLE;
                    r_op_ready <= 1'b1;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_op_ready <= 1'b1;
                end
            endcase
        end
    end

    assign op_ready  = r_op_ready;
    assign op_done   = r_op_done;
    assign op_err    = r_op_err;
    assign op_found  = r_op_found;
    assign op_rindex = r_op_rindex;
    assign op_rentry = r_op_rentry;
    assign s0_rvalid = r_s0_rvalid;
    assign s1_rvalid = r_s1_rvalid;
    assign s0_res    = r_s0_res;
    assign s1_res    = r_s1_res;
endmodule

// File: tb/tb_tlb_pipe.sv
// Randomized self-checking bench for tlb_pipe against an array-based TLB model.
module tb_tlb_pipe;
    import tlb_pkg::*;

    localparam int N     = 16;
    localparam int RES_W = 37;

    logic              clk = 1'b0;
    logic              resetn;
    logic              s0_req, s0_va_bit12, s1_req, s1_va_bit12;
    logic [18:0]       s0_vppn, s1_vppn;
    logic [9:0]        s0_asid, s1_asid;
    logic              s0_rvalid, s1_rvalid;
    logic [RES_W-1:0]  s0_res, s1_res;
    logic              op_valid, op_ready, op_done, op_err, op_found;
    logic [2:0]        op_code;
    logic [3:0]        op_index, op_rindex;
    logic [4:0]        op_inv;
    logic [9:0]        op_asid;
    logic [18:0]       op_vppn;
    logic [ENTRY_W-1:0] op_wentry, op_rentry;

    int n_tests = 0;
    int n_fail  = 0;

    tlb_entry_t m_ent [N];
    bit         m_e   [N];
    int         m_fptr;

    always #5 clk = ~clk;

    tlb_pipe #(.TLBNUM(N)) dut (
        .clk(clk), .resetn(resetn),
        .s0_req(s0_req), .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
        .s0_rvalid(s0_rvalid), .s0_res(s0_res),
        .s1_req(s1_req), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
        .s1_rvalid(s1_rvalid), .s1_res(s1_res),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_index(op_index),
        .op_inv(op_inv), .op_asid(op_asid), .op_vppn(op_vppn), .op_wentry(op_wentry),
        .op_done(op_done), .op_err(op_err), .op_found(op_found),
        .op_rindex(op_rindex), .op_rentry(op_rentry)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [RES_W-1:0] model_lookup(input logic [18:0] vppn, input logic b12,
                                                       input logic [9:0] asid);
        for (int i = 0; i < N; i++) begin
            tlb_entry_t t;
            tlb_page_t  pg;
            bit         big;
            t   = m_ent[i];
            big = (t.ps == 6'd21);
            if (m_e[i] && t.vppn[18:9] == vppn[18:9] && (big || t.vppn[8:0] == vppn[8:0]) &&
                (t.g || t.asid == asid)) begin
                pg = (big ? vppn[8] : b12) ? t.p1 : t.p0;
                return {1'b1, 4'(i), pg.ppn, t.ps, pg.plv, pg.mat, pg.d, pg.v};
            end
        end
        return '0;
    endfunction

    function automatic tlb_entry_t rand_entry();
        tlb_entry_t t;
        int k;
        t      = tlb_unpack({$urandom, $urandom, $urandom});
        t.vppn = {10'($urandom_range(0, 3)), 9'($urandom_range(0, 7))};
        t.asid = 10'($urandom_range(0, 3));
        t.e    = ($urandom_range(0, 4) != 0);
        k      = $urandom_range(0, 3);
        t.ps   = (k < 2) ? 6'd12 : (k == 2) ? 6'd21 : 6'($urandom);
        return t;
    endfunction

    task automatic lookup(input bit port, input logic [18:0] vppn, input logic b12,
                          input logic [9:0] asid, input bit drop, input string tag);
        logic [RES_W-1:0] exp;
        @(negedge clk);
        if (port) begin s1_req = 1; s1_vppn = vppn; s1_va_bit12 = b12; s1_asid = asid; end
        else      begin s0_req = 1; s0_vppn = vppn; s0_va_bit12 = b12; s0_asid = asid; end
        exp = model_lookup(vppn, b12, asid);
        @(posedge clk); #1;
        s0_req = 0; s1_req = 0;
        check({tag, "_vld"}, port ? s1_rvalid : s0_rvalid, 1);
        check({tag, "_res"}, port ? s1_res : s0_res, exp);
        if (drop) begin
            @(posedge clk); #1;
            check({tag, "_vld_drop"}, port ? s1_rvalid : s0_rvalid, 0);
            check({tag, "_hold"}, port ? s1_res : s0_res, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] code, input logic [3:0] idx, input logic [4:0] inv,
                            input logic [9:0] asid, input logic [18:0] vppn, input tlb_entry_t went);
        int n;
        n = 0;
        @(negedge clk);
        while (!op_ready && n < 10) begin @(negedge clk); n++; end
        check("ready_wait", op_ready, 1);
        op_valid = 1; op_code = code; op_index = idx; op_inv = inv;
        op_asid = asid; op_vppn = vppn; op_wentry = went;
        @(posedge clk); #1;
        op_valid = 0;
    endtask

    task automatic model_apply(input logic [2:0] code, input logic [3:0] idx, input logic [4:0] inv,
                               input logic [9:0] asid, input logic [18:0] vppn, input tlb_entry_t went);
        tlb_entry_t w;
        w = went;
        if (w.ps != 6'd12 && w.ps != 6'd21) w.ps = 6'd12;
        if (code == 3'd2) begin m_ent[idx] = w; m_e[idx] = w.e; end
        if (code == 3'd3) begin m_ent[m_fptr] = w; m_e[m_fptr] = w.e; m_fptr = (m_fptr + 1) % N; end
        if (code == 3'd4 && inv <= 6) begin
            for (int i = 0; i < N; i++) begin
                bit ae, va, sel;
                ae  = (m_ent[i].asid == asid);
                va  = (m_ent[i].vppn[18:9] == vppn[18:9]) &&
                      (m_ent[i].ps == 6'd21 || m_ent[i].vppn[8:0] == vppn[8:0]);
                case (inv)
                    0, 1:    sel = 1;
                    2:       sel = m_ent[i].g;
                    3:       sel = !m_ent[i].g;
                    4:       sel = !m_ent[i].g && ae;
                    5:       sel = !m_ent[i].g && ae && va;
                    default: sel = (m_ent[i].g || ae) && va;
                endcase
                if (sel) m_e[i] = 0;
            end
        end
    endtask

    task automatic do_op(input logic [2:0] code, input logic [3:0] idx, input logic [4:0] inv,
                         input logic [9:0] asid, input logic [18:0] vppn, input tlb_entry_t went,
                         input string tag);
        int n;
        logic [RES_W-1:0] srch;
        tlb_entry_t rd;
        bit exp_err;
        int fidx;
        exp_err = (code > 3'd4) || (code == 3'd4 && inv > 5'd6);
        srch    = model_lookup(vppn, 1'b0, asid);
        rd      = m_ent[idx];
        fidx    = m_fptr;
        start_op(code, idx, inv, asid, vppn, went);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!op_done && n < 8);
        check({tag, "_done"}, op_done, 1);
        check({tag, "_lat"}, n, 1);
        check({tag, "_err"}, op_err, exp_err);
        if (code == 3'd0) begin
            check({tag, "_found"}, op_found, srch[RES_W-1]);
            check({tag, "_sidx"}, op_rindex, srch[RES_W-2 -: 4]);
        end
        if (code == 3'd1) check({tag, "_rentry"}, op_rentry, m_e[idx] ? tlb_pack(rd) : '0);
        if (code == 3'd3) check({tag, "_fidx"}, op_rindex, fidx);
        if (!exp_err) model_apply(code, idx, inv, asid, vppn, went);
        @(posedge clk); #1;
        check({tag, "_pulse"}, op_done, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        tlb_entry_t t, t2;
        logic [RES_W-1:0] exp_old, exp_new;
        int k;
        resetn = 0; s0_req = 0; s1_req = 0; s0_vppn = 0; s1_vppn = 0; s0_va_bit12 = 0;
        s1_va_bit12 = 0; s0_asid = 0; s1_asid = 0; op_valid = 0; op_code = 0; op_index = 0;
        op_inv = 0; op_asid = 0; op_vppn = 0; op_wentry = 0;
        for (int i = 0; i < N; i++) begin m_ent[i] = '0; m_e[i] = 0; end
        m_fptr = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", op_ready, 1);
        check("rst_outs", {op_done, op_err, op_found, op_rindex, s0_rvalid, s1_rvalid}, 0);
        check("rst_rentry", op_rentry, 0);
        @(negedge clk); resetn = 1;
        lookup(0, 19'h0, 0, 10'h0, 1, "rst_s0");

        t = '0; t.e = 1; t.vppn = 19'h12345; t.ps = 6'd12; t.asid = 10'd3; t.g = 0;
        t.p0.ppn = 20'hAAAAA; t.p1.ppn = 20'hBBBBB; t.p1.plv = 2'd3; t.p1.mat = 2'd1;
        t.p1.d = 1; t.p1.v = 1;
        do_op(3'd2, 4'd5, 0, 0, 0, t, "wr5");
        lookup(1, 19'h12345, 1, 10'd3, 0, "s1_hit5");
        check("s1_hit5_const", s1_res, {1'b1, 4'd5, 20'hBBBBB, 6'd12, 2'd3, 2'd1, 1'b1, 1'b1});
        lookup(1, 19'h12345, 1, 10'd4, 1, "s1_asid_miss");
        check("s1_asid_miss_found", s1_res[RES_W-1], 0);

        t = '0; t.e = 1; t.vppn = 19'h40000; t.ps = 6'd21; t.g = 1; t.asid = 10'd9;
        t.p0.ppn = 20'h11111; t.p1.ppn = 20'h22222; t.p0.v = 1; t.p1.v = 1;
        do_op(3'd2, 4'd2, 0, 0, 0, t, "wr2_4m");
        lookup(0, 19'h401FF, 0, 10'($urandom), 0, "s0_4m_odd");
        check("s0_4m_odd_ppn", s0_res[31:12], 20'h22222);
        lookup(0, 19'h400FF, 1, 10'($urandom), 0, "s0_4m_even");
        check("s0_4m_even_ppn", s0_res[31:12], 20'h11111);

        do_op(3'd1, 4'd5, 0, 0, 0, '0, "rd5");
        do_op(3'd1, 4'd7, 0, 0, 0, '0, "rd7_empty");

        t = '0; t.e = 1; t.vppn = 19'h0ABCD; t.ps = 6'd12; t.asid = 10'd7; t.p0.ppn = 20'h33333;
        do_op(3'd2, 4'd3, 0, 0, 0, t, "wr3");
        do_op(3'd2, 4'd9, 0, 0, 0, t, "wr9");
        do_op(3'd0, 0, 0, 10'd7, 19'h0ABCD, '0, "srch_dup");
        check("srch_dup_idx", {op_found, op_rindex}, {1'b1, 4'd3});

        do_op(3'd4, 0, 5'd5, 10'd3, 19'h12345, '0, "inv5");
        lookup(1, 19'h12345, 1, 10'd3, 0, "inv5_gone");
        check("inv5_gone_found", s1_res[RES_W-1], 0);
        lookup(0, 19'h401FF, 0, 10'd3, 0, "inv5_g_kept");
        check("inv5_g_kept_idx", s0_res[RES_W-1 -: 5], {1'b1, 4'd2});
        do_op(3'd4, 0, 5'd7, 0, 0, '0, "inv7_err");
        lookup(0, 19'h0ABCD, 0, 10'd7, 0, "inv7_unchanged");
        do_op(3'd6, 4'd2, 0, 0, 0, '0, "illegal6");
        lookup(1, 19'h401FF, 0, 10'd0, 0, "illegal_unchanged");

        // Search racing a WR commit: pre-commit contents, then new ones a cycle later.
        t2 = '0; t2.e = 1; t2.g = 1; t2.vppn = 19'h7FFFF; t2.ps = 6'd12; t2.p0.ppn = 20'h55555;
        exp_old = model_lookup(19'h7FFFF, 0, 0);
        start_op(3'd2, 4'd12, 0, 0, 0, t2);
        s0_req = 1; s0_vppn = 19'h7FFFF; s0_va_bit12 = 0; s0_asid = 0;
        @(posedge clk); #1;
        check("coll_done", op_done, 1);
        check("coll_old", s0_res, exp_old);
        model_apply(3'd2, 4'd12, 0, 0, 0, t2);
        exp_new = model_lookup(19'h7FFFF, 0, 0);
        @(posedge clk); #1;
        s0_req = 0;
        check("coll_new", s0_res, exp_new);
        check("coll_new_found", s0_res[RES_W-1], 1);

        for (int i = 0; i <= N; i++) begin
            t = rand_entry();
            do_op(3'd3, 0, 0, 0, 0, t, "fill");
        end
        check("fill_wrap", op_rindex, 0);

        for (int it = 0; it < 150; it++) begin
            k = $urandom_range(0, 9);
            t = rand_entry();
            case (k)
                0, 1, 2, 3: lookup(k[0], t.vppn, 1'($urandom), t.asid, k == 3, "rnd_lk");
                4: do_op(3'd2, 4'($urandom), 0, 0, 0, t, "rnd_wr");
                5: do_op(3'd3, 0, 0, 0, 0, t, "rnd_fill");
                6: do_op(3'd1, 4'($urandom), 0, 0, 0, '0, "rnd_rd");
                7: do_op(3'd0, 0, 0, t.asid, t.vppn, '0, "rnd_srch");
                8: do_op(3'd4, 0, 5'($urandom_range(0, 7)), t.asid, t.vppn, '0, "rnd_inv");
                default: do_op(3'($urandom_range(5, 7)), 0, 0, 0, 0, t, "rnd_ill");
            endcase
        end

        // Reset landing on the EXEC edge of a WR must abort it entirely.
        t = '0; t.e = 1; t.g = 1; t.vppn = 19'h6AAAA; t.ps = 6'd12;
        start_op(3'd2, 4'd1, 0, 0, 0, t);
        resetn = 0;
        @(posedge clk); #1;
        check("mrst_no_done0", op_done, 0);
        @(posedge clk); #1;
        check("mrst_no_done1", op_done, 0);
        check("mrst_ready", op_ready, 1);
        for (int i = 0; i < N; i++) m_e[i] = 0;
        m_fptr = 0;
        @(negedge clk); resetn = 1;
        lookup(0, 19'h6AAAA, 0, 10'd0, 0, "mrst_wr_miss");
        check("mrst_wr_miss_found", s0_res[RES_W-1], 0);
        lookup(1, 19'h401FF, 0, 10'd0, 0, "mrst_old_miss");
        do_op(3'd3, 0, 0, 0, 0, rand_entry(), "mrst_fill0");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
